// File: rtl/systolic_seq_if.sv
// Command, operand-bank and array-edge signals of the systolic array sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface systolic_seq_if #(
    parameter int N     = 4,
    parameter int D_W   = 8,
    parameter int K_MAX = 16
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);

    logic             start;
    logic [KW-1:0]    k_len;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [N*D_W-1:0] a_rd_data;
    logic [N*D_W-1:0] b_rd_data;
    logic [N*D_W-1:0] a_feed;
    logic [N*D_W-1:0] b_feed;
    logic [N-1:0]     feed_vld;
    logic [N-1:0]     init;

    modport master (
        output start, k_len, a_rd_data, b_rd_data,
        input  busy, done, rd_en, rd_addr, a_feed, b_feed, feed_vld, init
    );

    modport slave (
        input  start, k_len, a_rd_data, b_rd_data,
        output busy, done, rd_en, rd_addr, a_feed, b_feed, feed_vld, init
    );
endinterface

// File: rtl/systolic_seq.sv
// Sequencer for an N x N systolic array: reads K-deep operand banks, skews lane i
// by i cycles, and tags first/flush beats with init so PEs restart and emit sums.
module systolic_seq #(
    parameter int N       = 4,
    parameter int D_W     = 8,
    parameter int K_MAX   = 16,
    parameter int LAT_ARR = 2*N-1
) (
    input logic           clk,
    input logic           rst,
    systolic_seq_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);
    localparam int CW = $clog2(N + LAT_ARR + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_sat;
    logic [CW-1:0] cnt;
    logic          last_rd;

    logic          vld_p0;
    logic          init_p0;
    logic [D_W-1:0] a_sk [N][N];
    logic [D_W-1:0] b_sk [N][N];
    logic [N-1:0]   vld_sk [N];
    logic [N-1:0]   init_sk [N];

    always_comb begin
        k_sat   = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
        last_rd = ((KW'(bus.rd_addr) + KW'(1)) == k_r);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = (k_sat == '0) ? DONE : FEED;
            FEED:    if (last_rd) state_n = DRAIN;
            DRAIN:   if (cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            k_r         <= '0;
            cnt         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
        end else begin
            state       <= state_n;
            bus.busy    <= (state_n != IDLE);
            bus.done    <= (state_n == DONE);
            bus.rd_en   <= (state_n == FEED);
            bus.rd_addr <= (state == FEED && !last_rd) ? bus.rd_addr + AW'(1) : '0;
            if (state == IDLE && bus.start)
                k_r <= k_sat;
            // Drain spans the lane N-1 flush skew plus the array latency.
            if (state == FEED)
                cnt <= CW'(N + LAT_ARR);
            else if (state == DRAIN && cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    // p0: tags aligned with bank read data; flush beat follows the last read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0  <= 1'b0;
            init_p0 <= 1'b0;
            for (int i = 0; i < N; i++) begin
                vld_sk[i]  <= '0;
                init_sk[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    a_sk[i][j] <= '0;
                    b_sk[i][j] <= '0;
                end
            end
        end else begin
            vld_p0  <= bus.rd_en;
            init_p0 <= (bus.rd_en && bus.rd_addr == '0) || (vld_p0 && !bus.rd_en);
            // Skew: lane i taps stage i; data is zeroed on entry when not valid.
            for (int i = 0; i < N; i++) begin
                a_sk[i][0]    <= vld_p0 ? bus.a_rd_data[i*D_W +: D_W] : '0;
                b_sk[i][0]    <= vld_p0 ? bus.b_rd_data[i*D_W +: D_W] : '0;
                vld_sk[i][0]  <= vld_p0;
                init_sk[i][0] <= init_p0;
                for (int j = 1; j < N; j++) begin
                    a_sk[i][j]    <= a_sk[i][j-1];
                    b_sk[i][j]    <= b_sk[i][j-1];
                    vld_sk[i][j]  <= vld_sk[i][j-1];
                    init_sk[i][j] <= init_sk[i][j-1];
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign bus.a_feed[g*D_W +: D_W] = a_sk[g][g];
        assign bus.b_feed[g*D_W +: D_W] = b_sk[g][g];
        assign bus.feed_vld[g]          = vld_sk[g][g];
        assign bus.init[g]              = init_sk[g][g];
    end
endmodule

// File: doc/systolic_seq.md
# systolic_seq

Sequencer for an N×N systolic array of `pe` instances. It accepts a matrix-multiply command and reads the K-deep A-row and B-column operand banks. It skews the operand streams so that lane i lags lane 0 by i cycles, and generates the per-lane `init` pulses that restart and later flush PE accumulators. It sits between the operand buffers and the array edge, and signals `done` once the last PE result has been emitted.

## Interface

Parameters:
- `N`, 4: array dimension; number of A lanes and number of B lanes.
- `D_W`, 8: operand width.
- `K_MAX`, 16: maximum reduction depth.
- `LAT_ARR`, 2*N-1: cycles from the lane N-1 flush beat leaving this block until the corner PE's `valid_D`.

Ports:
- `clk`  in  1: clock, all logic on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: command strobe, sampled only in IDLE.
- `k_len`  in  $clog2(K_MAX+1): reduction depth, sampled with `start`.
- `busy`  out  1: high from the cycle after start acceptance through the DONE cycle.
- `done`  out  1: one-cycle pulse.
- `rd_en`  out  1: operand bank read enable. Banks are shared-address with a 1-cycle synchronous read.
- `rd_addr`  out  $clog2(K_MAX): k index.
- `a_rd_data`  in  N*D_W: bank read data, lane i at bits [i*D_W +: D_W].
- `b_rd_data`  in  N*D_W: same layout as `a_rd_data`.
- `a_feed`  out  N*D_W: skewed A stream to array column 0.
- `b_feed`  out  N*D_W: skewed B stream to array row 0.
- `feed_vld`  out  N: per-lane data-valid.
- `init`  out  N: per-lane init, travelling with `a_feed`; the array forwards it.

## Operation

FSM states: IDLE → FEED → DRAIN → DONE → IDLE.
- **IDLE.** On `start`=1, latch `k_len`; values above K_MAX saturate to K_MAX.
  - Latched k ≥ 1: go to FEED.
  - Latched k = 0: go directly to DONE; no reads, no `init`, no `feed_vld`.
- **FEED.**
  - Lasts exactly k cycles.
  - `rd_en`=1, `rd_addr` = 0, 1, …, k-1.
  - A tag travels with each beat: "first" marks addr 0.
- **DRAIN.**
  - Inserts one internal flush beat: data 0, `feed_vld`=0, init tag set.
  - Counts down until the flush beat of lane N-1 has been issued plus LAT_ARR cycles, then goes to DONE.
- **DONE.** One cycle; `done`=1 and `busy`=1.

Skew path:
- Lane i output = bank data passed through 1+i pipeline registers.
- `feed_vld[i]` and `init[i]` are delayed identically, so each lane's data, valid and init stay aligned.
- `a_feed`/`b_feed` lanes are forced to 0 whenever `feed_vld[i]`=0.
- `init[i]` pulses twice per command:
  - On the lane's first element (restarts the accumulator).
  - On the lane's flush beat (emits the sum).

Other rules:
- `start` outside IDLE is ignored; there is no queueing.
- Reset, at any point including mid-FEED or mid-DRAIN:
  - All outputs and all skew, tag and counter registers clear to 0.
  - FSM returns to IDLE.
  - In-flight data is discarded.

## Timing

Start sampled at edge S with latched depth k ≥ 1:
- `busy` = 1 from cycle S+1.
- `rd_en`=1 in cycles S+1…S+k; `rd_addr`=j in cycle S+1+j.
- Lane i:
  - `feed_vld[i]`=1 in cycles S+3+i … S+2+i+k.
  - `init[i]`=1 in cycle S+3+i (first element) and in cycle S+3+i+k (flush beat).
- `done`=1 in cycle S+k+N+2+LAT_ARR; `busy` falls the following cycle.
- Earliest next accepted start: the edge ending the first IDLE cycle after DONE.

Start with latched k=0: `done`=1 in cycle S+1.

Every output is registered; there are no combinational input-to-output paths.

## Test plan

1. **Reset.** Hold `rst`=0 for 3 cycles, then release → `busy`, `done`, `rd_en`, `rd_addr`, feeds, `feed_vld` and `init` are all 0; FSM is in IDLE.
2. **Basic command (N=4, LAT_ARR=7).** `start` at edge S with `k_len`=3 →
   - `rd_addr` 0,1,2 in S+1..S+3.
   - `feed_vld[2]` high S+5..S+7; `init[2]` at S+5 and S+8.
   - `done` at S+16 only.
3. **Skew and zeroing.** Bank returns lane i = 0x10*i + addr →
   - `a_feed` lane 3 shows 0x30, 0x31, 0x32 in S+6..S+8 and 0 otherwise.
   - `b_feed` behaves identically.
4. **Zero depth.** `k_len`=0 → `done` at S+1; no `rd_en`, `feed_vld` or `init` ever asserted.
5. **Saturation and busy.**
   - `k_len`=20 → exactly 16 reads, addresses 0..15.
   - A second `start` during FEED is ignored: exactly one `done`.
6. **Mid-operation reset.**
   - `rst`=0 during FEED at k=2 → all outputs 0 immediately and no `done`.
   - A new start after release completes with nominal timing.
